// File: rtl/spraid_pkg.sv
// Shared RAID-type constants, rebuild FSM encoding and source-set helpers.
// The VF_* states only exist when SPRAID_VERIFY_EN is defined.
package spraid_pkg;

  localparam logic [3:0] RAID1 = 4'd0;
  localparam logic [3:0] RAID0 = 4'd1;
  localparam logic [3:0] RAID5 = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_WR_WAIT  = 3'd4,
`ifdef SPRAID_VERIFY_EN
    S_VF_ISSUE = 3'd5,
    S_VF_WAIT  = 3'd6,
`endif
    S_NEXT     = 3'd7
  } state_t;

  // RAID0 carries no redundancy, so there is nothing to rebuild from.
  function automatic logic type_ok(input logic [3:0] raid_type);
    case (raid_type)
      RAID1, RAID5: return 1'b1;
      RAID0:        return 1'b0;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] drive_bit(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [3:0] src_set(input logic [3:0] raid_type, input logic [1:0] failed);
    if (raid_type == RAID1) return (failed != 2'd0) ? 4'b0001 : 4'b0010;
    return ~drive_bit(failed);
  endfunction

endpackage

// File: rtl/spraid_wait_timer.sv
// Drive busy-wait qualifier with timeout for the rebuild sequencer.
// Down-counter loaded on each issue cycle; terminal count flags the timeout.
module spraid_wait_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       active,
  input  logic [3:0] mask,
  input  logic [3:0] drv_busy,
  output logic       ready,
  output logic       timeout
);

  localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Busy is not trusted in the first wait cycle: the drive may not have raised it yet.
  always_comb begin
    ready   = active && !first_q && ((drv_busy & mask) == 4'd0);
    timeout = active && !ready && (cnt_q == '0);
    cnt_d   = cnt_q;
    first_d = first_q;
    if (load) begin
      cnt_d   = LOAD_VAL;
      first_d = 1'b1;
    end else if (active) begin
      first_d = 1'b0;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/raid_rebuild_seq.sv
// RAID1/RAID5 rebuild sequencer: read sources, write reconstructed byte to the replaced drive.
// Optional per-byte read-back verify enabled by SPRAID_VERIFY_EN.
//
// state    | meaning
// IDLE     | waiting for start
// RD_ISSUE | read strobe on source drives
// RD_WAIT  | wait source busy, capture rebuild byte
// WR_ISSUE | write strobe on failed drive
// WR_WAIT  | wait failed-drive busy
// VF_ISSUE | read back failed drive (verify build)
// VF_WAIT  | wait, compare read-back (verify build)
// NEXT     | abort check, finish or advance address
module raid_rebuild_seq
  import spraid_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        raid_type,
  input  logic [1:0]        failed_drive,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [3:0]        drv_read,
  output logic [3:0]        drv_write,
  output logic [ADDR_W-1:0] drv_addr,
  output logic [7:0]        drv_wdata,
  input  logic [7:0]        drv_rdata0,
  input  logic [7:0]        drv_rdata1,
  input  logic [7:0]        drv_rdata2,
  input  logic [7:0]        drv_rdata3,
  input  logic [3:0]        drv_busy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] progress_addr
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
  logic [3:0]        type_q, type_d;
  logic [1:0]        failed_q, failed_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d, err_q, err_d;

  logic [7:0] rdata [4];
  logic [7:0] rd_xor;
  logic [3:0] src_mask, tgt_mask, wait_mask;
  logic       tmr_load, tmr_active, tmr_ready, tmr_timeout;

  assign rdata    = '{drv_rdata0, drv_rdata1, drv_rdata2, drv_rdata3};
  assign src_mask = src_set(type_q, failed_q);
  assign tgt_mask = drive_bit(failed_q);

  // RAID1 has a single source bit set, so the same XOR reduction covers both modes.
  always_comb begin
    rd_xor = '0;
    for (int i = 0; i < 4; i++) begin
      if (src_mask[i]) rd_xor = rd_xor ^ rdata[i];
    end
  end

  spraid_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .active   (tmr_active),
    .mask     (wait_mask),
    .drv_busy (drv_busy),
    .ready    (tmr_ready),
    .timeout  (tmr_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      end_q    <= '0;
      type_q   <= '0;
      failed_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      end_q    <= end_d;
      type_q   <= type_d;
      failed_q <= failed_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    end_d    = end_q;
    type_d   = type_q;
    failed_d = failed_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (type_ok(raid_type) && (start_addr <= end_addr)) begin
            addr_d   = start_addr;
            end_d    = end_addr;
            type_d   = raid_type;
            failed_d = failed_drive;
            state_d  = S_RD_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (tmr_timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (tmr_ready) begin
          data_d  = rd_xor;
          state_d = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (tmr_timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (tmr_ready) begin
`ifdef SPRAID_VERIFY_EN
          state_d = S_VF_ISSUE;
`else
          state_d = S_NEXT;
`endif
        end
      end
`ifdef SPRAID_VERIFY_EN
      S_VF_ISSUE: state_d = S_VF_WAIT;
      S_VF_WAIT: begin
        if (tmr_timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (tmr_ready) begin
          if (rdata[failed_q] != data_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
`endif
      S_NEXT: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (addr_q == end_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drv_read   = '0;
    drv_write  = '0;
    wait_mask  = '0;
    tmr_load   = 1'b0;
    tmr_active = 1'b0;
    case (state_q)
      S_RD_ISSUE: begin
        drv_read = src_mask;
        tmr_load = 1'b1;
      end
      S_RD_WAIT: begin
        wait_mask  = src_mask;
        tmr_active = 1'b1;
      end
      S_WR_ISSUE: begin
        drv_write = tgt_mask;
        tmr_load  = 1'b1;
      end
      S_WR_WAIT: begin
        wait_mask  = tgt_mask;
        tmr_active = 1'b1;
      end
`ifdef SPRAID_VERIFY_EN
      S_VF_ISSUE: begin
        drv_read = tgt_mask;
        tmr_load = 1'b1;
      end
      S_VF_WAIT: begin
        wait_mask  = tgt_mask;
        tmr_active = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign drv_addr      = addr_q;
  assign progress_addr = addr_q;
  assign drv_wdata     = data_q;

endmodule

// File: tb/tb_raid_rebuild_seq.sv
// Directed bench for raid_rebuild_seq with a simple four-drive model (memory, busy latency, busy force).
// The verify scenario is only compiled when SPRAID_VERIFY_EN is defined.
module tb_raid_rebuild_seq;

  localparam int ADDR_W = 16;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [3:0]        raid_type = '0;
  logic [1:0]        failed_drive = '0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [3:0]        drv_read, drv_write, drv_busy;
  logic [ADDR_W-1:0] drv_addr, progress_addr;
  logic [7:0]        drv_wdata, drv_rdata0, drv_rdata1, drv_rdata2, drv_rdata3;
  logic              busy, done, err;

  int errors = 0;
  int checks = 0;

  raid_rebuild_seq #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .raid_type     (raid_type),
    .failed_drive  (failed_drive),
    .start_addr    (start_addr),
    .end_addr      (end_addr),
    .drv_read      (drv_read),
    .drv_write     (drv_write),
    .drv_addr      (drv_addr),
    .drv_wdata     (drv_wdata),
    .drv_rdata0    (drv_rdata0),
    .drv_rdata1    (drv_rdata1),
    .drv_rdata2    (drv_rdata2),
    .drv_rdata3    (drv_rdata3),
    .drv_busy      (drv_busy),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .progress_addr (progress_addr)
  );

  always #5 clk = ~clk;

  // Drive model: bench-loaded contents, write overlay tagged per test, busy latency after a strobe.
  int         busy_lat = 0;
  logic [3:0] busy_force = '0;
  int         epoch = 1;
  bit         drop_writes = 1'b0;
  int         cyc = 0;
  logic [7:0] mem  [4][256];
  logic [7:0] wmem [4][256];
  int         wtag [4][256];
  int         bcnt [4];
  logic [7:0] rdata [4];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (drv_read[i] || drv_write[i]) bcnt[i] <= busy_lat;
      else if (bcnt[i] > 0) bcnt[i] <= bcnt[i] - 1;
      if (drv_write[i] && !drop_writes) begin
        wmem[i][drv_addr[7:0]] <= drv_wdata;
        wtag[i][drv_addr[7:0]] <= epoch;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      drv_busy[i] = busy_force[i] | (bcnt[i] != 0);
      rdata[i] = (wtag[i][drv_addr[7:0]] == epoch && !drop_writes) ? wmem[i][drv_addr[7:0]]
                                                                    : mem[i][drv_addr[7:0]];
    end
  end

  assign drv_rdata0 = rdata[0];
  assign drv_rdata1 = rdata[1];
  assign drv_rdata2 = rdata[2];
  assign drv_rdata3 = rdata[3];

  // Monitor: strobe logs and event counters, sampled mid-cycle.
  int                rd_cnt [4];
  int                done_total = 0, err_total = 0, overlap_total = 0, gap_total = 0;
  int                last_rd_cyc = 0, last_err_cyc = 0;
  bit                in_run = 1'b0;
  int                wr_drv_q [$];
  logic [7:0]        wr_data_q [$];
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [ADDR_W-1:0] rd_addr_q [$];
  logic [3:0]        rd_mask_q [$];

  always @(negedge clk) begin
    if (drv_read != '0) begin
      last_rd_cyc = cyc;
      rd_addr_q.push_back(drv_addr);
      rd_mask_q.push_back(drv_read);
    end
    for (int i = 0; i < 4; i++) begin
      if (drv_read[i]) rd_cnt[i]++;
      if (drv_write[i]) begin
        wr_drv_q.push_back(i);
        wr_data_q.push_back(drv_wdata);
        wr_addr_q.push_back(drv_addr);
      end
    end
    if ((drv_read != '0 && drv_write != '0) || $countones(drv_write) > 1) overlap_total++;
    if (done) done_total++;
    if (err) begin
      err_total++;
      last_err_cyc = cyc;
    end
    if (in_run && !busy && !done && !err) gap_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] t, input logic [1:0] f,
                        input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea);
    raid_type    = t;
    failed_drive = f;
    start_addr   = sa;
    end_addr     = ea;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_end(input int max, output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < max && !got_done && !got_err; i++) begin
      @(negedge clk);
      got_done = done;
      got_err  = err;
    end
  endtask

  function automatic int rd_sum();
    return rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (drv_read !== 4'b0 || drv_write !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: read=%b write=%b, required 0000/0000", drv_read, drv_write);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b, required 0/0/0", busy, done, err);
    end
    checks++;
    if (drv_addr !== '0 || progress_addr !== '0 || drv_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: addr=%h progress=%h wdata=%h, required 0", drv_addr, progress_addr, drv_wdata);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_raid1();
    logic [7:0] exp_d [3] = '{8'hA5, 8'h5A, 8'hFF};
    int  r0, ro, wb, db, gb, rb;
    bit  gd, ge;
    epoch++;
    mem[0][8'h10] = 8'hA5;
    mem[0][8'h11] = 8'h5A;
    mem[0][8'h12] = 8'hFF;
    r0 = rd_cnt[0]; ro = rd_sum() - rd_cnt[0];
    wb = wr_drv_q.size(); db = done_total; gb = gap_total; rb = rd_addr_q.size();
    launch(4'd0, 2'd2, 16'h0010, 16'h0012);
    in_run = 1'b1;
    wait_end(300, gd, ge);
    in_run = 1'b0;
    repeat (3) tick();
    checks++;
    if (!gd || ge) begin
      errors++;
      $display("FAIL raid1_end: done=%b err=%b, required done=1 err=0", gd, ge);
    end
    checks++;
    if (rd_cnt[0] - r0 != 3 || (rd_sum() - rd_cnt[0]) - ro != 0) begin
      errors++;
      $display("FAIL raid1_reads: drive0=%0d others=%0d, required 3/0", rd_cnt[0] - r0, (rd_sum() - rd_cnt[0]) - ro);
    end
    checks++;
    if (rd_addr_q.size() != rb + 3) begin
      errors++;
      $display("FAIL raid1_rd_addr: %0d reads logged, required 3", rd_addr_q.size() - rb);
    end else if (rd_addr_q[rb] !== 16'h0010 || rd_addr_q[rb+1] !== 16'h0011 || rd_addr_q[rb+2] !== 16'h0012) begin
      errors++;
      $display("FAIL raid1_rd_addr: %h %h %h, required 0010 0011 0012", rd_addr_q[rb], rd_addr_q[rb+1], rd_addr_q[rb+2]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (wb + k >= wr_drv_q.size()) begin
        errors++;
        $display("FAIL raid1_wr%0d: no write, required %h to drive 2", k, exp_d[k]);
      end else if (wr_drv_q[wb+k] != 2 || wr_data_q[wb+k] !== exp_d[k] || wr_addr_q[wb+k] !== ADDR_W'(16 + k)) begin
        errors++;
        $display("FAIL raid1_wr%0d: drive=%0d data=%h addr=%h, required drive=2 data=%h addr=%h",
                 k, wr_drv_q[wb+k], wr_data_q[wb+k], wr_addr_q[wb+k], exp_d[k], ADDR_W'(16 + k));
      end
    end
    checks++;
    if (wr_drv_q.size() - wb != 3 || done_total - db != 1) begin
      errors++;
      $display("FAIL raid1_counts: writes=%0d done=%0d, required 3/1", wr_drv_q.size() - wb, done_total - db);
    end
    checks++;
    if (gap_total != gb) begin
      errors++;
      $display("FAIL raid1_busy: busy low for %0d cycles mid-run, required 0", gap_total - gb);
    end
    checks++;
    if (busy !== 1'b0 || progress_addr !== 16'h0012) begin
      errors++;
      $display("FAIL raid1_idle: busy=%b progress=%h, required 0/0012", busy, progress_addr);
    end
  endtask

  // RAID1 with drive 0 failed sources drive 1; busy latency exercises the wait states.
  task automatic test_raid1_busy_wait();
    int wb;
    bit gd, ge;
    epoch++;
    busy_lat = 3;
    mem[1][8'h05] = 8'h3C;
    mem[1][8'h06] = 8'hC3;
    wb = wr_drv_q.size();
    launch(4'd0, 2'd0, 16'h0005, 16'h0006);
    wait_end(300, gd, ge);
    busy_lat = 0;
    repeat (6) tick();
    checks++;
    if (!gd || ge) begin
      errors++;
      $display("FAIL r1f0_end: done=%b err=%b, required done=1 err=0", gd, ge);
    end
    checks++;
    if (wr_drv_q.size() != wb + 2) begin
      errors++;
      $display("FAIL r1f0_writes: %0d writes, required 2", wr_drv_q.size() - wb);
    end else if (wr_drv_q[wb] != 0 || wr_drv_q[wb+1] != 0 || wr_data_q[wb] !== 8'h3C || wr_data_q[wb+1] !== 8'hC3) begin
      errors++;
      $display("FAIL r1f0_writes: drives %0d,%0d data %h,%h, required 0,0 3C,C3",
               wr_drv_q[wb], wr_drv_q[wb+1], wr_data_q[wb], wr_data_q[wb+1]);
    end
  endtask

  task automatic test_raid5();
    logic [1:0] fv [2] = '{2'd3, 2'd1};
    logic [7:0] ev [2] = '{8'hCC, 8'h07};
    logic [3:0] mv [2] = '{4'b0111, 4'b1101};
    int  wb, rb;
    bit  gd, ge;
    for (int v = 0; v < 2; v++) begin
      epoch++;
      if (v == 0) begin
        mem[0][0] = 8'h0F; mem[1][0] = 8'hF0; mem[2][0] = 8'h33; mem[3][0] = 8'h77;
      end else begin
        mem[0][0] = 8'h01; mem[1][0] = 8'hEE; mem[2][0] = 8'h02; mem[3][0] = 8'h04;
      end
      wb = wr_drv_q.size();
      rb = rd_mask_q.size();
      launch(4'd5, fv[v], 16'h0000, 16'h0000);
      wait_end(200, gd, ge);
      repeat (2) tick();
      checks++;
      if (!gd || ge) begin
        errors++;
        $display("FAIL raid5_end%0d: done=%b err=%b, required done=1 err=0", v, gd, ge);
      end
      checks++;
      if (rd_mask_q.size() <= rb || rd_mask_q[rb] !== mv[v]) begin
        errors++;
        $display("FAIL raid5_rdmask%0d: read strobes %0d logged, first=%b, required %b", v,
                 rd_mask_q.size() - rb, (rd_mask_q.size() > rb) ? rd_mask_q[rb] : 4'b0, mv[v]);
      end
      checks++;
      if (wr_drv_q.size() != wb + 1) begin
        errors++;
        $display("FAIL raid5_wr%0d: %0d writes, required 1", v, wr_drv_q.size() - wb);
      end else if (wr_drv_q[wb] != int'(fv[v]) || wr_data_q[wb] !== ev[v]) begin
        errors++;
        $display("FAIL raid5_wr%0d: drive=%0d data=%h, required drive=%0d data=%h",
                 v, wr_drv_q[wb], wr_data_q[wb], fv[v], ev[v]);
      end
    end
  endtask

  task automatic test_reject();
    logic [3:0]        tv [3] = '{4'd1, 4'd7, 4'd0};
    logic [ADDR_W-1:0] sv [3] = '{16'h0000, 16'h0000, 16'h0005};
    logic [ADDR_W-1:0] ev [3] = '{16'h0000, 16'h0000, 16'h0004};
    int rs, wb;
    logic e1, b1, e2;
    for (int v = 0; v < 3; v++) begin
      rs = rd_sum();
      wb = wr_drv_q.size();
      launch(tv[v], 2'd2, sv[v], ev[v]);
      @(negedge clk);
      e1 = err; b1 = busy;
      @(negedge clk);
      e2 = err;
      repeat (4) tick();
      checks++;
      if (e1 !== 1'b1 || e2 !== 1'b0 || b1 !== 1'b0) begin
        errors++;
        $display("FAIL reject%0d_err: err=%b,%b busy=%b, required err=1,0 busy=0", v, e1, e2, b1);
      end
      checks++;
      if (rd_sum() != rs || wr_drv_q.size() != wb || busy !== 1'b0) begin
        errors++;
        $display("FAIL reject%0d_quiet: reads=%0d writes=%0d busy=%b, required 0/0/0",
                 v, rd_sum() - rs, wr_drv_q.size() - wb, busy);
      end
    end
  endtask

  task automatic test_timeout();
    int rs, wb;
    bit gd, ge;
    busy_force = 4'b0001;
    rs = rd_sum();
    wb = wr_drv_q.size();
    launch(4'd0, 2'd2, 16'h0020, 16'h0021);
    wait_end(100, gd, ge);
    repeat (4) tick();
    checks++;
    if (!ge || gd) begin
      errors++;
      $display("FAIL timeout_err: err=%b done=%b, required err=1 done=0", ge, gd);
    end
    checks++;
    if (last_err_cyc - last_rd_cyc != TMO + 1) begin
      errors++;
      $display("FAIL timeout_delay: err %0d cycles after read strobe, required %0d", last_err_cyc - last_rd_cyc, TMO + 1);
    end
    checks++;
    if (rd_sum() - rs != 1 || wr_drv_q.size() != wb || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_quiet: reads=%0d writes=%0d busy=%b, required 1/0/0", rd_sum() - rs, wr_drv_q.size() - wb, busy);
    end
    busy_force = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    int rs, wb, db;
    bit gd, ge;
    epoch++;
    rs = rd_sum();
    wb = wr_drv_q.size();
    db = done_total;
    abort = 1'b1;
    launch(4'd0, 2'd2, 16'h0000, 16'h0002);
    wait_end(200, gd, ge);
    abort = 1'b0;
    repeat (3) tick();
    checks++;
    if (!ge || gd || done_total != db) begin
      errors++;
      $display("FAIL abort_err: err=%b done=%b, required err=1 done=0", ge, gd);
    end
    checks++;
    if (rd_sum() - rs != 1 || wr_drv_q.size() - wb != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_ops: reads=%0d writes=%0d busy=%b, required 1/1/0", rd_sum() - rs, wr_drv_q.size() - wb, busy);
    end
  endtask

  task automatic test_back_to_back();
    int wb, db;
    bit gd, ge;
    epoch++;
    busy_lat = 2;
    mem[0][8'h30] = 8'h11;
    mem[0][8'h31] = 8'h22;
    mem[1][8'h40] = 8'h12;
    mem[2][8'h40] = 8'h34;
    mem[3][8'h40] = 8'h56;
    wb = wr_drv_q.size();
    db = done_total;
    launch(4'd0, 2'd1, 16'h0030, 16'h0031);
    repeat (4) tick();
    launch(4'd5, 2'd0, 16'h0040, 16'h0040);
    wait_end(300, gd, ge);
    checks++;
    if (!gd || ge || wr_drv_q.size() != wb + 2) begin
      errors++;
      $display("FAIL b2b_first: done=%b err=%b writes=%0d, required 1/0/2", gd, ge, wr_drv_q.size() - wb);
    end else if (wr_drv_q[wb] != 1 || wr_drv_q[wb+1] != 1 || wr_data_q[wb] !== 8'h11 || wr_data_q[wb+1] !== 8'h22) begin
      errors++;
      $display("FAIL b2b_first: drives %0d,%0d data %h,%h, required 1,1 11,22",
               wr_drv_q[wb], wr_drv_q[wb+1], wr_data_q[wb], wr_data_q[wb+1]);
    end
    tick();
    launch(4'd5, 2'd0, 16'h0040, 16'h0040);
    wait_end(300, gd, ge);
    busy_lat = 0;
    repeat (5) tick();
    checks++;
    if (!gd || ge || wr_drv_q.size() != wb + 3) begin
      errors++;
      $display("FAIL b2b_second: done=%b err=%b writes=%0d, required 1/0/3", gd, ge, wr_drv_q.size() - wb);
    end else if (wr_drv_q[wb+2] != 0 || wr_data_q[wb+2] !== 8'h70) begin
      errors++;
      $display("FAIL b2b_second: drive=%0d data=%h, required drive=0 data=70", wr_drv_q[wb+2], wr_data_q[wb+2]);
    end
    checks++;
    if (done_total - db != 2) begin
      errors++;
      $display("FAIL b2b_done: %0d done pulses, required 2", done_total - db);
    end
  endtask

  task automatic test_reset_mid();
    int wb;
    bit seen, gd, ge;
    epoch++;
    busy_lat = 5;
    mem[0][8'h02] = 8'h81;
    mem[0][8'h03] = 8'h82;
    launch(4'd0, 2'd2, 16'h0002, 16'h0003);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = (drv_write != '0);
    end
    tick();
    checks++;
    if (!seen || busy !== 1'b1 || drv_addr !== 16'h0002) begin
      errors++;
      $display("FAIL rstmid_pre: write_seen=%b busy=%b addr=%h, required 1/1/0002", seen, busy, drv_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (drv_read !== 4'b0 || drv_write !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ctrl: read=%b write=%b busy=%b done=%b err=%b, required all 0",
               drv_read, drv_write, busy, done, err);
    end
    checks++;
    if (drv_addr !== '0 || progress_addr !== '0 || drv_wdata !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_data: addr=%h progress=%h wdata=%h, required 0", drv_addr, progress_addr, drv_wdata);
    end
    tick();
    reset = 1'b0;
    busy_lat = 0;
    repeat (7) tick();
    epoch++;
    mem[0][8'h00] = 8'h44;
    wb = wr_drv_q.size();
    launch(4'd0, 2'd2, 16'h0000, 16'h0000);
    wait_end(200, gd, ge);
    repeat (2) tick();
    checks++;
    if (!gd || ge || wr_drv_q.size() != wb + 1) begin
      errors++;
      $display("FAIL rstmid_after: done=%b err=%b writes=%0d, required 1/0/1", gd, ge, wr_drv_q.size() - wb);
    end else if (wr_drv_q[wb] != 2 || wr_data_q[wb] !== 8'h44 || wr_addr_q[wb] !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_after: drive=%0d data=%h addr=%h, required 2/44/0000", wr_drv_q[wb], wr_data_q[wb], wr_addr_q[wb]);
    end
  endtask

  task automatic test_end_addr_max();
    int wb, db, rs;
    bit gd, ge;
    epoch++;
    mem[0][8'hFE] = 8'h9A;
    mem[0][8'hFF] = 8'hB7;
    wb = wr_drv_q.size();
    db = done_total;
    launch(4'd0, 2'd1, 16'hFFFE, 16'hFFFF);
    wait_end(200, gd, ge);
    rs = rd_sum();
    repeat (8) tick();
    checks++;
    if (!gd || ge || wr_drv_q.size() != wb + 2) begin
      errors++;
      $display("FAIL maxaddr_end: done=%b err=%b writes=%0d, required 1/0/2", gd, ge, wr_drv_q.size() - wb);
    end else if (wr_data_q[wb] !== 8'h9A || wr_data_q[wb+1] !== 8'hB7 || wr_addr_q[wb+1] !== 16'hFFFF || wr_drv_q[wb+1] != 1) begin
      errors++;
      $display("FAIL maxaddr_end: data %h,%h last addr=%h drive=%0d, required 9A,B7 FFFF 1",
               wr_data_q[wb], wr_data_q[wb+1], wr_addr_q[wb+1], wr_drv_q[wb+1]);
    end
    checks++;
    if (rd_sum() != rs || done_total - db != 1 || progress_addr !== 16'hFFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL maxaddr_stop: extra reads=%0d done=%0d progress=%h busy=%b, required 0/1/FFFF/0",
               rd_sum() - rs, done_total - db, progress_addr, busy);
    end
  endtask

`ifdef SPRAID_VERIFY_EN
  task automatic test_verify_mismatch();
    int wb, db;
    bit gd, ge;
    epoch++;
    drop_writes = 1'b1;
    mem[0][8'h50] = 8'h5A;
    mem[2][8'h50] = 8'h00;
    wb = wr_drv_q.size();
    db = done_total;
    launch(4'd0, 2'd2, 16'h0050, 16'h0051);
    wait_end(200, gd, ge);
    repeat (3) tick();
    drop_writes = 1'b0;
    checks++;
    if (!ge || gd || done_total != db) begin
      errors++;
      $display("FAIL verify_err: err=%b done=%b, required err=1 done=0", ge, gd);
    end
    checks++;
    if (wr_drv_q.size() - wb != 1 || busy !== 1'b0 || progress_addr !== 16'h0050) begin
      errors++;
      $display("FAIL verify_stop: writes=%0d busy=%b progress=%h, required 1/0/0050",
               wr_drv_q.size() - wb, busy, progress_addr);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;
    end
    test_reset();
    test_raid1();
    test_raid1_busy_wait();
    test_raid5();
    test_reject();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_end_addr_max();
`ifdef SPRAID_VERIFY_EN
    test_verify_mismatch();
`endif
    checks++;
    if (overlap_total != 0) begin
      errors++;
      $display("FAIL strobe_exclusive: %0d cycles with overlapping strobes, required 0", overlap_total);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
